// File: rtl/dynamixel_sync_tx.sv
// Dynamixel 1.0 SYNC_WRITE (0x83) transmitter: one broadcast packet to up to NUM_SERVOS servos, 8N1 UART.
// Latency: TXD start bit and UART_DIR=1 in the cycle after start; busy lasts (8+N*(DATA_BYTES+1))*10*BIT_CYCLES cycles.
// Backpressure: none; start is honoured only in IDLE, otherwise dropped. Optional macro DXL_TX_GUARD_EN adds a bus-turnaround hold.
module dynamixel_sync_tx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 1000000,
    parameter int NUM_SERVOS = 4,
    parameter int DATA_BYTES = 2,
    parameter int GUARD_BITS = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [7:0]                           reg_addr,
    input  logic [8*NUM_SERVOS-1:0]              ids,
    input  logic [8*DATA_BYTES*NUM_SERVOS-1:0]   data,
    input  logic [NUM_SERVOS-1:0]                servo_mask,
    output logic                                 TXD,
    output logic                                 UART_DIR,
    output logic                                 busy,
    output logic                                 done
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD;
    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam int SW = (NUM_SERVOS > 1) ? $clog2(NUM_SERVOS) : 1;
`ifdef DXL_TX_GUARD_EN
    localparam int GUARD_CYCLES = GUARD_BITS * BIT_CYCLES;
    localparam int GW = $clog2(GUARD_CYCLES + 1);
`endif

    if (NUM_SERVOS < 1 || NUM_SERVOS > 16 || DATA_BYTES < 1 || DATA_BYTES > 4 ||
        GUARD_BITS < 1 || BIT_CYCLES < 1) begin : g_bad_params
        $error("dynamixel_sync_tx: parameter out of range");
    end

    // NEXT_BYTE is the zero-cycle byte select evaluated on the last stop-bit cycle; it is never a resting state.
    typedef enum logic [2:0] {
        S_IDLE, S_START_BIT, S_DATA_BITS, S_STOP_BIT, S_NEXT_BYTE, S_DONE
`ifdef DXL_TX_GUARD_EN
        , S_GUARD
`endif
    } state_t;

    // Where in the packet the byte currently on the wire came from.
    typedef enum logic [1:0] {SEG_HDR, SEG_SERVO, SEG_CHK} seg_t;

    state_t                              state_q, state_d;
    seg_t                                seg_q, seg_d;
    logic [CW-1:0]                       baud_q, baud_d;
    logic [2:0]                          bit_q, bit_d;
    logic [2:0]                          hdr_q, hdr_d;
    logic [SW-1:0]                       servo_q, servo_d;
    logic [2:0]                          sub_q, sub_d;
    logic [7:0]                          byte_q, byte_d;
    logic [7:0]                          chk_q, chk_d;
    logic [7:0]                          len_q, len_d;
    logic [7:0]                          addr_q, addr_d;
    logic [8*NUM_SERVOS-1:0]             ids_q, ids_d;
    logic [8*DATA_BYTES*NUM_SERVOS-1:0]  data_q, data_d;
    logic [NUM_SERVOS-1:0]               mask_q, mask_d;
    logic                                txd_q, txd_d, dir_q, dir_d, busy_q, busy_d, done_q, done_d;
`ifdef DXL_TX_GUARD_EN
    logic [GW-1:0]                       guard_q, guard_d;
`endif

    logic [4:0]    pop_cnt;
    logic          baud_end;
    logic [SW:0]   sel;
    logic          nxt_last, nxt_add;
    seg_t          nxt_seg;
    logic [2:0]    nxt_hdr, nxt_sub;
    logic [SW-1:0] nxt_servo;
    logic [7:0]    nxt_byte;

    // Lowest masked-in servo index at or above 'from'; MSB flags whether one exists.
    function automatic logic [SW:0] find_servo(input logic [NUM_SERVOS-1:0] m, input int from);
        logic [SW:0] r;
        r = '0;
        for (int k = NUM_SERVOS - 1; k >= 0; k--) begin
            if (k >= from && m[k]) r = {1'b1, SW'(k)};
        end
        return r;
    endfunction

    function automatic logic [7:0] hdr_byte(input logic [2:0] h, input logic [7:0] len, input logic [7:0] addr);
        case (h)
            3'd0, 3'd1: return 8'hFF;
            3'd2:       return 8'hFE;
            3'd3:       return len;
            3'd4:       return 8'h83;
            3'd5:       return addr;
            default:    return 8'(DATA_BYTES);
        endcase
    endfunction

    assign baud_end = (baud_q == CW'(BIT_CYCLES - 1));

    // Number of servos selected at the moment of acceptance.
    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < NUM_SERVOS; i++) pop_cnt = pop_cnt + 5'(servo_mask[i]);
    end

    // Select the byte that follows the current one; masked-out slots are skipped in the same cycle.
    always_comb begin
        sel       = '0;
        nxt_last  = 1'b0;
        nxt_seg   = seg_q;
        nxt_hdr   = hdr_q;
        nxt_servo = servo_q;
        nxt_sub   = sub_q;
        nxt_byte  = 8'h00;
        case (seg_q)
            SEG_HDR: begin
                if (hdr_q != 3'd6) begin
                    nxt_hdr  = hdr_q + 3'd1;
                    nxt_byte = hdr_byte(hdr_q + 3'd1, len_q, addr_q);
                end else begin
                    sel = find_servo(mask_q, 0);
                    if (sel[SW]) begin
                        nxt_seg   = SEG_SERVO;
                        nxt_servo = sel[SW-1:0];
                        nxt_sub   = 3'd0;
                        nxt_byte  = ids_q[8*int'(sel[SW-1:0]) +: 8];
                    end else begin
                        nxt_seg  = SEG_CHK;
                        nxt_byte = ~chk_q;
                    end
                end
            end
            SEG_SERVO: begin
                if (sub_q != 3'(DATA_BYTES)) begin
                    nxt_sub  = sub_q + 3'd1;
                    nxt_byte = data_q[8*(DATA_BYTES*int'(servo_q) + int'(sub_q)) +: 8];
                end else begin
                    sel = find_servo(mask_q, int'(servo_q) + 1);
                    if (sel[SW]) begin
                        nxt_servo = sel[SW-1:0];
                        nxt_sub   = 3'd0;
                        nxt_byte  = ids_q[8*int'(sel[SW-1:0]) +: 8];
                    end else begin
                        nxt_seg  = SEG_CHK;
                        nxt_byte = ~chk_q;
                    end
                end
            end
            default: nxt_last = 1'b1;
        endcase
        // The two leading FF bytes and the checksum itself stay out of the sum.
        nxt_add = (nxt_seg != SEG_CHK) && !(nxt_seg == SEG_HDR && nxt_hdr < 3'd2);
    end

    // Packet sequencer and bit timer; all outputs are registered.
    always_comb begin
        state_d = state_q;  seg_d   = seg_q;   baud_d  = baud_q;  bit_d  = bit_q;
        hdr_d   = hdr_q;    servo_d = servo_q; sub_d   = sub_q;   byte_d = byte_q;
        chk_d   = chk_q;    len_d   = len_q;   addr_d  = addr_q;  ids_d  = ids_q;
        data_d  = data_q;   mask_d  = mask_q;  txd_d   = txd_q;   dir_d  = dir_q;
        busy_d  = busy_q;   done_d  = 1'b0;
`ifdef DXL_TX_GUARD_EN
        guard_d = guard_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = reg_addr;
                    ids_d   = ids;
                    data_d  = data;
                    mask_d  = servo_mask;
                    len_d   = 8'(int'(pop_cnt) * (DATA_BYTES + 1) + 4);
                    chk_d   = 8'h00;
                    seg_d   = SEG_HDR;
                    hdr_d   = 3'd0;
                    servo_d = '0;
                    sub_d   = 3'd0;
                    baud_d  = '0;
                    if (pop_cnt == 5'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_START_BIT;
                        byte_d  = 8'hFF;
                        txd_d   = 1'b0;
                        dir_d   = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_START_BIT: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    txd_d   = byte_q[0];
                    state_d = S_DATA_BITS;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_DATA_BITS: begin
                if (baud_end) begin
                    baud_d = '0;
                    byte_d = {1'b1, byte_q[7:1]};
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = S_STOP_BIT;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = byte_q[1];
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_STOP_BIT: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (nxt_last) begin
`ifdef DXL_TX_GUARD_EN
                        guard_d = '0;
                        state_d = S_GUARD;
`else
                        dir_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
`endif
                    end else begin
                        seg_d   = nxt_seg;
                        hdr_d   = nxt_hdr;
                        servo_d = nxt_servo;
                        sub_d   = nxt_sub;
                        byte_d  = nxt_byte;
                        if (nxt_add) chk_d = chk_q + nxt_byte;
                        txd_d   = 1'b0;
                        state_d = S_START_BIT;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
`ifdef DXL_TX_GUARD_EN
            S_GUARD: begin
                if (guard_q == GW'(GUARD_CYCLES - 1)) begin
                    dir_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    guard_d = guard_q + GW'(1);
                end
            end
`endif
            S_DONE: state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
                dir_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous return to an idle, released bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;  seg_q   <= SEG_HDR; baud_q <= '0;    bit_q  <= '0;
            hdr_q   <= '0;      servo_q <= '0;      sub_q  <= '0;    byte_q <= '0;
            chk_q   <= '0;      len_q   <= '0;      addr_q <= '0;    ids_q  <= '0;
            data_q  <= '0;      mask_q  <= '0;      txd_q  <= 1'b1;  dir_q  <= 1'b0;
            busy_q  <= 1'b0;    done_q  <= 1'b0;
`ifdef DXL_TX_GUARD_EN
            guard_q <= '0;
`endif
        end else begin
            state_q <= state_d; seg_q   <= seg_d;   baud_q <= baud_d; bit_q  <= bit_d;
            hdr_q   <= hdr_d;   servo_q <= servo_d; sub_q  <= sub_d;  byte_q <= byte_d;
            chk_q   <= chk_d;   len_q   <= len_d;   addr_q <= addr_d; ids_q  <= ids_d;
            data_q  <= data_d;  mask_q  <= mask_d;  txd_q  <= txd_d;  dir_q  <= dir_d;
            busy_q  <= busy_d;  done_q  <= done_d;
`ifdef DXL_TX_GUARD_EN
            guard_q <= guard_d;
`endif
        end
    end

    assign TXD      = txd_q;
    assign UART_DIR = dir_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_dynamixel_sync_tx.sv
// Bench for dynamixel_sync_tx: packet-level model checked every cycle, plus a UART decoder against literal packets.
// Latency: model expects the start bit one cycle after the accepting edge.
// Backpressure: starts while the model is busy or in its done cycle are expected to be dropped.
module tb_dynamixel_sync_tx;

    localparam int NS   = 2;
    localparam int DB   = 2;
    localparam int CLKF = 50000000;
    localparam int BAUD = 1000000;
    localparam int BC   = CLKF / BAUD;
`ifdef DXL_TX_GUARD_EN
    localparam int GC = 2 * BC;
`else
    localparam int GC = 0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        reg_addr = 8'h00;
    logic [8*NS-1:0]   ids = '0;
    logic [8*DB*NS-1:0] data = '0;
    logic [NS-1:0]     mask = '0;
    logic              TXD, UART_DIR, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    dynamixel_sync_tx #(
        .CLK_FREQ(CLKF), .BAUD(BAUD), .NUM_SERVOS(NS), .DATA_BYTES(DB), .GUARD_BITS(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .reg_addr(reg_addr), .ids(ids),
        .data(data), .servo_mask(mask), .TXD(TXD), .UART_DIR(UART_DIR), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- packet-level model ----------------
    logic       m_active = 1'b0;
    int         m_t = 0, m_data_cyc = 0, m_tx = 0;
    logic [7:0] m_q[$];

    always @(posedge clk or posedge reset) begin : model
        int n, sum;
        logic [7:0] ck;
        if (reset) begin
            m_active = 1'b0;
        end else if (m_active) begin
            m_t++;
            if (m_t > m_tx + 1) m_active = 1'b0;
        end else if (start) begin
            n = 0;
            for (int i = 0; i < NS; i++) if (mask[i]) n++;
            m_q.delete();
            m_q.push_back(8'hFF); m_q.push_back(8'hFF); m_q.push_back(8'hFE);
            m_q.push_back(8'(n * (DB + 1) + 4));
            m_q.push_back(8'h83); m_q.push_back(reg_addr); m_q.push_back(8'(DB));
            for (int i = 0; i < NS; i++) begin
                if (mask[i]) begin
                    m_q.push_back(ids[8*i +: 8]);
                    for (int j = 0; j < DB; j++) m_q.push_back(data[8*(i*DB + j) +: 8]);
                end
            end
            sum = 0;
            for (int i = 2; i < m_q.size(); i++) sum += int'(m_q[i]);
            ck = 8'(sum);
            m_q.push_back(~ck);
            m_data_cyc = (n == 0) ? 0 : m_q.size() * 10 * BC;
            m_tx       = (n == 0) ? 0 : m_data_cyc + GC;
            m_t        = 1;
            m_active   = 1'b1;
        end
    end

    // Every cycle: outputs {TXD,UART_DIR,busy,done} against the model.
    always @(negedge clk) begin : cmp
        logic [3:0] e, a;
        logic [7:0] cur;
        int b, p;
        logic bitv;
        if (!m_active) e = 4'b1000;
        else if (m_t <= m_data_cyc) begin
            b = (m_t - 1) / (10 * BC);
            p = ((m_t - 1) % (10 * BC)) / BC;
            cur = m_q[b];
            if (p == 0) bitv = 1'b0;
            else if (p == 9) bitv = 1'b1;
            else bitv = cur[p-1];
            e = {bitv, 3'b110};
        end else if (m_t <= m_tx) e = 4'b1110;
        else e = 4'b1001;
        a = {TXD, UART_DIR, busy, done};
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0d: got txd/dir/busy/done=%b, expected %b", m_t, a, e);
        end
    end

    // ---------------- independent observers ----------------
    logic [7:0] rx_q[$];
    int busy_cnt = 0, done_cnt = 0, dir_cnt = 0, txd_low_cnt = 0;

    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
        if (UART_DIR === 1'b1) dir_cnt++;
        if (TXD === 1'b0) txd_low_cnt++;
    end

    initial begin : rx
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (TXD === 1'b0) begin
                repeat (BC / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BC) @(negedge clk);
                    b[i] = TXD;
                end
                repeat (BC) @(negedge clk);
                rx_q.push_back(b);
            end
        end
    end

    // ---------------- literal expectations ----------------
    logic [7:0] exp_a[$] = '{8'hFF, 8'hFF, 8'hFE, 8'h0A, 8'h83, 8'h1E, 8'h02,
                             8'h01, 8'h00, 8'h02, 8'h02, 8'h00, 8'h01, 8'h4E};
    logic [7:0] exp_b[$] = '{8'hFF, 8'hFF, 8'hFE, 8'h07, 8'h83, 8'h1E, 8'h02,
                             8'h02, 8'h00, 8'h01, 8'h54};

    task automatic clear_obs();
        @(posedge clk); #1;
        rx_q.delete();
        busy_cnt = 0; done_cnt = 0; dir_cnt = 0; txd_low_cnt = 0;
    endtask

    task automatic send(input logic [7:0] a, input logic [15:0] id, input logic [31:0] d, input logic [1:0] m);
        @(negedge clk);
        reg_addr = a; ids = id; data = d; mask = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'd0, done === 1'b1}, 32'd1);
    endtask

    task automatic check_rx(input string name, input logic [7:0] exp[$]);
        check({name, "_nbytes"}, rx_q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < rx_q.size()) check($sformatf("%s_byte%0d", name, i), rx_q[i], exp[i]);
        end
    endtask

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {TXD, UART_DIR, busy, done}, 4'b1000);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // both servos
        clear_obs();
        send(8'h1E, 16'h0201, 32'h0100_0200, 2'b11);
        check("first_cycle_startbit", {TXD, UART_DIR, busy, done}, 4'b0110);
        wait_done("done_A", 9000);
        repeat (20) @(negedge clk);
        check_rx("pkt_A", exp_a);
        check("busy_len_A", busy_cnt, 7000 + GC);
        check("done_pulses_A", done_cnt, 1);

        // servo 1 only
        clear_obs();
        send(8'h1E, 16'h0201, 32'h0100_0200, 2'b10);
        wait_done("done_B", 9000);
        repeat (20) @(negedge clk);
        check_rx("pkt_B", exp_b);
        check("busy_len_B", busy_cnt, 5500 + GC);
        check("done_pulses_B", done_cnt, 1);

        // empty mask
        clear_obs();
        send(8'h1E, 16'h0201, 32'h0100_0200, 2'b00);
        check("empty_done_next", {TXD, UART_DIR, busy, done}, 4'b1001);
        repeat (30) @(negedge clk);
        check("empty_done_pulses", done_cnt, 1);
        check("empty_busy", busy_cnt, 0);
        check("empty_dir", dir_cnt, 0);
        check("empty_txd_low", txd_low_cnt, 0);

        // second start mid-packet is dropped
        clear_obs();
        send(8'h1E, 16'h0201, 32'h0100_0200, 2'b11);
        repeat (2998) @(negedge clk);
        send(8'h55, 16'h0403, 32'h1234_5678, 2'b10);
        wait_done("done_D", 9000);
        repeat (600) @(negedge clk);
        check_rx("pkt_D", exp_a);
        check("busy_len_D", busy_cnt, 7000 + GC);
        check("done_pulses_D", done_cnt, 1);

        // asynchronous reset mid data bit
        clear_obs();
        send(8'h1E, 16'h0201, 32'h0100_0200, 2'b11);
        repeat (1233) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset_outputs", {TXD, UART_DIR, busy, done}, 4'b1000);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (700) @(negedge clk);
        check("reset_no_done", done_cnt, 0);
        clear_obs();
        send(8'h1E, 16'h0201, 32'h0100_0200, 2'b11);
        wait_done("done_E", 9000);
        repeat (20) @(negedge clk);
        check_rx("pkt_E", exp_a);
        check("busy_len_E", busy_cnt, 7000 + GC);
        check("done_pulses_E", done_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dynamixel_sync_tx.md
Name: dynamixel_sync_tx

Overview:
- Parametrised successor to the single-servo Dynamixel UART driver.
- Builds and transmits one Dynamixel 1.0 SYNC_WRITE (0x83) packet addressed to up to NUM_SERVOS servos in a single frame.
- Uses 8N1 UART timing and drives half-duplex direction control.
- Sits between the SPI-fed register bank and the GPIO_1 TXD / direction pins; replaces per-servo WRITE_DATA sequencing.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 1000000, UART bit rate. BIT_CYCLES = CLK_FREQ/BAUD (integer division, remainder dropped).
- NUM_SERVOS, 4, number of servo slots, 1..16.
- DATA_BYTES, 2, parameter bytes written per servo, 1..4.
- GUARD_BITS, 2, turnaround hold in bit periods; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- start  in  1  request one packet; honoured only while busy=0.
- reg_addr  in  8  control-table start address.
- ids  in  8*NUM_SERVOS  servo i ID at [8i+:8].
- data  in  8*DATA_BYTES*NUM_SERVOS  servo i value at [8*DATA_BYTES*i +: 8*DATA_BYTES].
- servo_mask  in  NUM_SERVOS  1 = include servo i.
- TXD  out  1  UART serial out, idle high.
- UART_DIR  out  1  1 = bus driven (TX), 0 = release/receive.
- busy  out  1  packet in progress.
- done  out  1  one-cycle pulse at packet end.

Behaviour:
- Reset (async, any state, including mid-byte): TXD=1, UART_DIR=0, busy=0, done=0; FSM returns to IDLE. No partial byte resumes after reset.
- Start acceptance:
  - A start high in IDLE latches reg_addr, ids, data and servo_mask in the same edge.
  - Inputs are ignored thereafter until the next IDLE.
  - start while busy=1 is ignored; it is not queued.
- Active count N = popcount(servo_mask).
- N=0: no transmission. done pulses in the cycle after start; busy, UART_DIR and TXD stay idle.
- Packet byte order:
  - FF, FF, FE (broadcast ID), LEN, 83, reg_addr, DATA_BYTES.
  - Then, for each masked-in servo in ascending index: ID, followed by its data bytes LSB first.
  - Then CHK.
  - LEN = N*(DATA_BYTES+1)+4, 8-bit.
  - CHK = ~(sum of ID through last parameter byte) mod 256. The two FF bytes are excluded.
  - Total bytes = 8 + N*(DATA_BYTES+1).
- FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT, NEXT_BYTE (combinational select, zero cycles), GUARD (optional feature only), DONE.
- First-byte timing: the cycle after start is accepted, busy=1, UART_DIR=1 and TXD=0 (start bit of first FF).
- Bit timing:
  - Each bit is held exactly BIT_CYCLES cycles.
  - Data bits go LSB first.
  - Stop bit = 1.
  - Bytes are sent back to back with no idle gap.
- Checksum accumulator: cleared on acceptance, adds each byte from FE through the last parameter byte as that byte's start bit begins.
- Masked-out servo slots are skipped with no time cost.
- End of packet: on the last cycle of CHK's stop bit, the next cycle has busy=0, UART_DIR=0, done=1 for one cycle, TXD=1.
- start sampled in that DONE cycle is ignored; it is accepted from the following cycle.
- Packet duration = (8 + N*(DATA_BYTES+1)) * 10 * BIT_CYCLES cycles.

Optional Feature:
- Macro: DXL_TX_GUARD_EN.
- Defined: after CHK's stop bit, the FSM enters GUARD.
  - UART_DIR stays 1, TXD stays 1, busy stays 1 for GUARD_BITS*BIT_CYCLES cycles.
  - Then the DONE behaviour above applies.
  - Reset during GUARD clears immediately.
- Undefined: the GUARD state and its counter are not synthesised; end of packet is as described in Behaviour.

Test Plan:
- NUM_SERVOS=2, DATA_BYTES=2, BAUD=1M:
  - Stimulus: ids={02,01}, reg_addr=1E, data servo0=0200, servo1=0100, mask=11, start pulse.
  - Response: TXD decodes FF FF FE 0A 83 1E 02 01 00 02 02 00 01 4E; busy high for exactly 7000 cycles; single done pulse.
- Same config, mask=10:
  - Response: FF FF FE 07 83 1E 02 02 00 01 54; busy high 5500 cycles.
- mask=00, start pulse:
  - Response: done the next cycle; TXD stays 1 and UART_DIR stays 0 throughout.
- Second start pulse at cycle 3000 of a packet:
  - Response: ignored; exactly one packet and one done pulse.
- reset asserted mid-data-bit at cycle 1234:
  - Response: TXD=1, UART_DIR=0, busy=0 asynchronously; no done pulse; a new start then sends a full, correct packet.
- DXL_TX_GUARD_EN defined, GUARD_BITS=2:
  - Response: UART_DIR falls 100 cycles after the last stop bit ends; done is coincident with UART_DIR falling.
